io_handshake_responder: RTL and testbench

IO_HANDSHAKE_RESPONDER -- requirements
Module: io_handshake_responder

---
 rtl/io_handshake_responder.sv | 175 +++++++++++++++++
 tb/tb_io_handshake_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/io_handshake_responder.sv
// Services processor IN/OUT requests: debounced key capture of the switch word for IN,
// and a sequential binary-to-BCD conversion shown on eight seven-segment digits for OUT.
module io_handshake_responder #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        input_flag,
  input  logic        output_flag,
  input  logic [31:0] out_data,
  input  logic        insert,
  input  logic [14:0] SW,
  output logic [31:0] user_input,
  output logic        stall,
  output logic        done,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic [2:0]  state_dbg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WAIT_PRESS   = 3'd1,
    S_WAIT_RELEASE = 3'd2,
    S_CONVERT      = 3'd3,
    S_DONE         = 3'd4
  } state_t;

  state_t          state;
  logic            sync1, sync2;
  logic            db_level, db_prev;
  logic [CW-1:0]   db_cnt;
  logic            press_edge, release_edge;
  logic [31:0]     conv;
  logic [39:0]     bcd, bcd_adj, bcd_next;
  logic [4:0]      bit_cnt;
  logic [7:0][6:0] hex_q, seg_next;
  logic            seen;

  // Key is active-low, so the released level is 1 and reset returns there.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      db_level <= 1'b1;
      db_prev  <= 1'b1;
      db_cnt   <= '0;
    end else begin
      sync1   <= insert;
      sync2   <= sync1;
      db_prev <= db_level;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press_edge   = db_prev & ~db_level;
  assign release_edge = ~db_prev & db_level;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_DASH;
    endcase
  endfunction

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[38:0], conv[31]};
  end

  // Display image of the final BCD value; digits above the top nonzero one are blanked.
  always_comb begin
    seg_next = '0;
    seen     = 1'b0;
    if (|bcd_next[39:32]) begin
      seg_next = {8{SEG_DASH}};
    end else begin
      for (int i = 7; i >= 0; i--) begin
        seen = seen | (bcd_next[4*i +: 4] != 4'd0) | (i == 0);
        seg_next[i] = seen ? seg7(bcd_next[4*i +: 4]) : SEG_BLANK;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      conv       <= '0;
      bcd        <= '0;
      bit_cnt    <= '0;
      user_input <= '0;
      hex_q      <= {8{SEG_BLANK}};
    end else begin
      case (state)
        S_IDLE: begin
          if (input_flag) begin
            state <= S_WAIT_PRESS;
          end else if (output_flag) begin
            conv    <= out_data;
            bcd     <= '0;
            bit_cnt <= '0;
            state   <= S_CONVERT;
          end
        end
        S_WAIT_PRESS: begin
          if (press_edge) begin
            user_input <= {17'b0, SW};
            state      <= S_WAIT_RELEASE;
          end
        end
        S_WAIT_RELEASE: begin
          if (release_edge) state <= S_DONE;
        end
        S_CONVERT: begin
          bcd     <= bcd_next;
          conv    <= {conv[30:0], 1'b0};
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            hex_q <= seg_next;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall = ((state == S_IDLE) && (input_flag || output_flag)) ||
                 (state == S_WAIT_PRESS) || (state == S_WAIT_RELEASE) ||
                 (state == S_CONVERT);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_io_handshake_responder.sv
// Bench for io_handshake_responder: IN and OUT requests with random values, key glitches,
// both-flags priority and reset during conversion, checked against a decimal display model.
module tb_io_handshake_responder;

  localparam int DB = 16;
  localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        input_flag = 1'b0;
  logic        output_flag = 1'b0;
  logic [31:0] out_data = '0;
  logic        insert = 1'b1;
  logic [14:0] SW = '0;
  logic [31:0] user_input;
  logic        stall, done;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad = 0;
  logic [55:0] exp_hex = {8{7'h7F}};
  logic [31:0] exp_user = '0;
  logic [31:0] exp_q[$];

  io_handshake_responder #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLK(clk), .reset(reset), .input_flag(input_flag), .output_flag(output_flag),
    .out_data(out_data), .insert(insert), .SW(SW), .user_input(user_input),
    .stall(stall), .done(done), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [55:0] hex_now();
    return {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  endfunction

  // Decimal display model: count digits, show that many, blank the rest.
  function automatic logic [55:0] model_hex(input logic [31:0] v);
    logic [55:0] r;
    longint unsigned x;
    int nd;
    r = '0;
    if (v > 32'd99999999) return {8{7'b0111111}};
    x = v;
    nd = 0;
    do begin
      nd++;
      x = x / 10;
    end while (x != 0);
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[7*i +: 7] = (i < nd) ? SEG[int'(x % 10)] : 7'h7F;
      x = x / 10;
    end
    return r;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (user_input !== 32'h0) begin bad++; $display("FAIL reset_user: got %h want 0", user_input); end
    total++; if (hex_now() !== {8{7'h7F}}) begin bad++; $display("FAIL reset_hex: got %h want %h", hex_now(), {8{7'h7F}}); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_output(input logic [31:0] v);
    int n;
    int hold_err;
    logic got;
    logic [55:0] want;
    want = model_hex(v);
    hold_err = 0;
    got = 1'b0;
    @(posedge clk); #1 output_flag = 1'b1; out_data = v;
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL out_idle_stall v=%0d: got %b want 1", v, stall); end
    n = 1;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk); #1;
      output_flag = $urandom_range(0, 1) == 0;
      input_flag = $urandom_range(0, 1) == 0;
      out_data = $urandom;
      n++;
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
      else if (stall !== 1'b1 || hex_now() !== exp_hex) hold_err++;
    end
    input_flag = 1'b0;
    output_flag = 1'b0;
    total++; if (!got) begin bad++; $display("FAIL out_timeout v=%0d: got no done want done (state %0d)", v, state_dbg); end
    total++; if (hold_err != 0) begin bad++; $display("FAIL out_hold v=%0d: got %0d bad cycles want 0", v, hold_err); end
    total++; if (n != 34) begin bad++; $display("FAIL out_latency v=%0d: got %0d want 34", v, n); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL out_done_stall v=%0d: got %b want 0", v, stall); end
    total++; if (hex_now() !== want) begin bad++; $display("FAIL out_hex v=%0d: got %h want %h", v, hex_now(), want); end
    exp_hex = want;
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL out_done_pulse v=%0d: got %b want 0", v, done); end
  endtask

  // IN request: optional simultaneous OUT flag, optional short key glitches before the real press.
  task automatic test_input(input logic [14:0] sw, input logic with_out, input int glitches);
    int k;
    int err;
    logic got;
    logic [31:0] want;
    err = 0;
    got = 1'b0;
    @(posedge clk); #1 input_flag = 1'b1; output_flag = with_out; out_data = $urandom; SW = sw;
    exp_q.push_back({17'b0, sw});
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL in_idle_stall: got %b want 1", stall); end
    @(posedge clk); #1 input_flag = 1'b0; output_flag = 1'b0;
    for (int g = 0; g < glitches; g++) begin
      insert = 1'b0;
      repeat ($urandom_range(1, DB - 4)) begin
        @(negedge clk); if (done !== 1'b0 || stall !== 1'b1) err++;
        @(posedge clk); #1 input_flag = $urandom_range(0, 1) == 0;
      end
      insert = 1'b1;
      repeat (6) begin
        @(negedge clk); if (done !== 1'b0 || stall !== 1'b1) err++;
        @(posedge clk); #1 input_flag = $urandom_range(0, 1) == 0;
      end
    end
    input_flag = 1'b0;
    if (glitches > 0) begin
      total++; if (user_input !== exp_user) begin bad++; $display("FAIL glitch_capture: got %h want %h", user_input, exp_user); end
    end
    insert = 1'b0;
    repeat (20) begin
      @(negedge clk); if (done !== 1'b0 || stall !== 1'b1) err++;
      @(posedge clk); #1;
    end
    insert = 1'b1;
    SW = 15'($urandom);
    k = 0;
    while (k < 40 && !got) begin
      @(posedge clk); #1 k++;
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
      else if (stall !== 1'b1) err++;
    end
    want = exp_q.pop_front();
    exp_user = want;
    total++; if (!got) begin bad++; $display("FAIL in_timeout: got no done want done (state %0d)", state_dbg); end
    total++; if (err != 0) begin bad++; $display("FAIL in_stall_done: got %0d bad cycles want 0", err); end
    total++; if (k < DB + 1 || k > DB + 4) begin bad++; $display("FAIL in_release_latency: got %0d want %0d..%0d", k, DB + 1, DB + 4); end
    total++; if (user_input !== want) begin bad++; $display("FAIL in_capture: got %h want %h", user_input, want); end
    total++; if (hex_now() !== exp_hex) begin bad++; $display("FAIL in_hex_kept: got %h want %h", hex_now(), exp_hex); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL in_done_stall: got %b want 0", stall); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_convert();
    @(posedge clk); #1 output_flag = 1'b1; out_data = 32'd12345;
    @(posedge clk); #1 output_flag = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    exp_hex = {8{7'h7F}};
    exp_user = '0;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall: got %b want 0", stall); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done: got %b want 0", done); end
    total++; if (hex_now() !== exp_hex) begin bad++; $display("FAIL rst_mid_hex: got %h want %h", hex_now(), exp_hex); end
    total++; if (user_input !== exp_user) begin bad++; $display("FAIL rst_mid_user: got %h want %h", user_input, exp_user); end
    @(posedge clk); #1 reset = 1'b0;
    test_output($urandom_range(0, 99999999));
  endtask

  task automatic test_output_boundaries();
    test_output(32'd1234);
    test_output(32'd0);
    test_output(32'd99999999);
    test_output(32'd100000000);
    test_output(32'hFFFFFFFF);
    test_output(32'd10);
  endtask

  task automatic test_output_random();
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: test_output($urandom_range(0, 999));
        1: test_output($urandom_range(1000, 99999999));
        2: test_output($urandom);
        default: test_output($urandom_range(99999990, 100000010));
      endcase
    end
  endtask

  task automatic test_back_to_back();
    test_input(15'h7FFF, 1'b0, 0);
    test_input(15'($urandom), 1'b0, 3);
    test_input(15'($urandom), 1'b1, 0);
    test_output($urandom);
    test_input(15'($urandom), 1'b0, 1);
  endtask

  initial begin
    test_reset();
    test_output_boundaries();
    test_output_random();
    test_back_to_back();
    test_reset_mid_convert();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
